// File: rtl/freq_meter_pkg.sv
// Shared definitions for the auto-ranging frequency meter: range codes, sequencer states, gate multipliers.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package freq_meter_pkg;

  localparam logic [1:0] RANGE_100K = 2'b00;
  localparam logic [1:0] RANGE_10K  = 2'b01;
  localparam logic [1:0] RANGE_1K   = 2'b10;

  localparam int MULT_100K = 1;
  localparam int MULT_10K  = 10;
  localparam int MULT_1K   = 100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_GATE  = 3'd2,
    ST_LATCH = 3'd3,
    ST_HOLD  = 3'd4
  } meas_state_t;

  // Gate multiplier for a range code; the unused code 11 behaves like 01.
  function automatic int gate_mult(input logic [1:0] code);
    int m;
    case (code)
      RANGE_100K: m = MULT_100K;
      RANGE_1K:   m = MULT_1K;
      default:    m = MULT_10K;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sig_edge_sync.sv
// Brings the asynchronous measured signal into the clk domain and emits a one-cycle pulse per rising edge.
// Latency: edge pulse appears 3 clk after the input rises (2 sync flops + registered detect).
// Backpressure: none; every clean rising edge produces exactly one pulse.
module sig_edge_sync (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_sig,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync2_d;
  logic r_edge;

  // Two-stage synchronizer, previous-value flop and registered rising-edge pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_d <= 1'b0;
      r_edge    <= 1'b0;
    end else begin
      r_sync1   <= i_sig;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
      r_edge    <= r_sync2 & ~r_sync2_d;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer: clear -> gate -> latch -> hold, counting synchronized signal edges over a range-dependent gate.
// Latency: result_valid and verdict pulses arrive gate_len+2 clk after the start/restart request is sampled.
// Backpressure: none; a start request in any state aborts the current measurement and restarts from CLEAR.
module freq_meas_ctrl
  import freq_meter_pkg::*;
#(
  parameter int CNT_W       = 14,
  parameter int GATE_BASE   = 50000,
  parameter int OVER_THRESH = 9999,
  parameter int LOW_THRESH  = 1000,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_sig_in,
  input  logic [1:0]       i_range_sel,
  input  logic             i_c_start,
  output logic             o_cnt_over,
  output logic             o_cnt_low,
  output logic [CNT_W-1:0] o_result,
  output logic [1:0]       o_result_range,
  output logic             o_result_valid,
  output logic             o_busy
);

  localparam int TMR_W = $clog2(MULT_1K * GATE_BASE);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [31:0]      OVER_LIM  = 32'(OVER_THRESH);
  localparam logic [31:0]      LOW_LIM   = 32'(LOW_THRESH);

  meas_state_t      r_state;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_range;
  logic [CNT_W-1:0] r_result;
  logic [1:0]       r_result_range;
  logic             r_valid;
  logic             r_over;
  logic             r_low;
  logic             r_busy;

  logic             w_edge;
  logic [TMR_W-1:0] w_gate_last;
  logic [31:0]      w_count32;

  sig_edge_sync u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_sig     (i_sig_in),
    .o_edge    (w_edge)
  );

  // Last gate-timer value for the range captured in CLEAR, and the count widened for threshold compares.
  always_comb begin
    w_gate_last = TMR_W'(GATE_BASE * gate_mult(r_range) - 1);
    w_count32   = 32'(r_count);
  end

  // Sequencer FSM with gate/hold timer, saturating edge counter and registered outputs.
  // The timer is reused to count HOLD cycles since GATE and HOLD never overlap.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      r_count        <= '0;
      r_range        <= 2'b00;
      r_result       <= '0;
      r_result_range <= 2'b00;
      r_valid        <= 1'b0;
      r_over         <= 1'b0;
      r_low          <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_over  <= 1'b0;
      r_low   <= 1'b0;
      if (i_c_start) begin
        // Start or abort: anything in flight is discarded, no verdicts emitted.
        r_state <= ST_CLEAR;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_busy <= 1'b0;
          end
          ST_CLEAR: begin
            r_count <= '0;
            r_timer <= '0;
            r_range <= i_range_sel;
            r_state <= ST_GATE;
            r_busy  <= 1'b1;
          end
          ST_GATE: begin
            if (w_edge && (r_count != CNT_MAX)) begin
              r_count <= r_count + 1'b1;
            end
            if (r_timer == w_gate_last) begin
              r_state <= ST_LATCH;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
            r_busy <= 1'b1;
          end
          ST_LATCH: begin
            r_result       <= r_count;
            r_result_range <= r_range;
            r_valid        <= 1'b1;
            if (w_count32 > OVER_LIM) begin
              r_over <= 1'b1;
            end else if (w_count32 < LOW_LIM) begin
              r_low <= 1'b1;
            end
            r_timer <= '0;
            r_state <= ST_HOLD;
            r_busy  <= 1'b0;
          end
          ST_HOLD: begin
            if (r_timer == HOLD_LAST) begin
              r_state <= ST_CLEAR;
              r_busy  <= 1'b1;
            end else begin
              r_timer <= r_timer + 1'b1;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_cnt_over     = r_over;
  assign o_cnt_low      = r_low;
  assign o_result       = r_result;
  assign o_result_range = r_result_range;
  assign o_result_valid = r_valid;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Bench for freq_meas_ctrl: table of directed measurements plus abort, LATCH-collision and mid-gate reset sequences.
// Latency: checks the start-to-result_valid delay of gate_len+2 and the 20-cycle HOLD before free-running restart.
// Backpressure: n/a; a second instance with a 6-bit counter exercises saturation.
module tb_freq_meas_ctrl;

  logic       clk;
  logic       reset_n;
  logic       sig_in;
  logic [1:0] range_sel;
  logic       c_start;

  logic        m_over, m_low, m_valid, m_busy;
  logic [13:0] m_result;
  logic [1:0]  m_range;
  logic        s_over, s_low, s_valid, s_busy;
  logic [5:0]  s_result;
  logic [1:0]  s_range;

  int total = 0;
  int bad   = 0;
  int sig_per = 0;

  freq_meas_ctrl #(
    .CNT_W(14), .GATE_BASE(100), .OVER_THRESH(9999), .LOW_THRESH(1000), .HOLD_CYCLES(20)
  ) u_main (
    .i_clk(clk), .i_reset_n(reset_n), .i_sig_in(sig_in), .i_range_sel(range_sel),
    .i_c_start(c_start), .o_cnt_over(m_over), .o_cnt_low(m_low), .o_result(m_result),
    .o_result_range(m_range), .o_result_valid(m_valid), .o_busy(m_busy)
  );

  freq_meas_ctrl #(
    .CNT_W(6), .GATE_BASE(100), .OVER_THRESH(50), .LOW_THRESH(10), .HOLD_CYCLES(20)
  ) u_sat (
    .i_clk(clk), .i_reset_n(reset_n), .i_sig_in(sig_in), .i_range_sel(range_sel),
    .i_c_start(c_start), .o_cnt_over(s_over), .o_cnt_low(s_low), .o_result(s_result),
    .o_result_range(s_range), .o_result_valid(s_valid), .o_busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Periodic measured signal: high for the first half of each sig_per-cycle period, 0 when sig_per is 0.
  initial begin
    int ph;
    ph = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      ph = ph + 1;
      if (ph >= sig_per) ph = 0;
      sig_in = (sig_per != 0) && (ph < sig_per / 2);
    end
  end

  typedef struct {
    logic [1:0] rng;
    int per;
    int glen;
    int tol;
    int exp_res;
    int exp_over;
    int exp_low;
    int exp2_res;
    int exp2_over;
    int exp2_low;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input int act, input int exp, input int tol);
    total++;
    if (act < exp - tol || act > exp + tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (+/-%0d)", nm, act, exp, tol);
    end
  endtask

  task automatic start_pulse();
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
  endtask

  // Counts negedges until the main instance shows result_valid, bounded by maxc.
  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_valid && n < maxc);
  endtask

  initial begin
    int n;
    int m;
    int quiet;

    //            rng    per glen  tol  res over low  res2 over2 low2
    vecs[0] = '{2'b00, 2, 100,   0,   50,  0, 1,  50, 0, 0};
    vecs[1] = '{2'b01, 2, 1000,  0,  500,  0, 1,  63, 1, 0};
    vecs[2] = '{2'b10, 8, 10000, 0, 1250,  0, 0,  63, 1, 0};
    vecs[3] = '{2'b00, 8, 100,   1,   12,  0, 1,  12, 0, 0};
    vecs[4] = '{2'b01, 4, 1000,  0,  250,  0, 1,  63, 1, 0};

    reset_n   = 1'b0;
    c_start   = 1'b0;
    range_sel = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_result", 32'(m_result), 0);
    chk("reset_busy", 32'(m_busy), 0);
    chk("reset_pulses", 32'({m_valid, m_over, m_low, s_valid, s_over, s_low}), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(m_busy), 0);

    for (int i = 0; i < 5; i++) begin
      sig_per   = vecs[i].per;
      range_sel = vecs[i].rng;
      repeat (20) @(negedge clk);
      start_pulse();
      wait_valid(vecs[i].glen + 50, n);
      chk($sformatf("row%0d_latency", i), n, vecs[i].glen + 2);
      chk_tol($sformatf("row%0d_result", i), 32'(m_result), vecs[i].exp_res, vecs[i].tol);
      chk($sformatf("row%0d_range", i), 32'(m_range), 32'(vecs[i].rng));
      chk($sformatf("row%0d_over", i), 32'(m_over), vecs[i].exp_over);
      chk($sformatf("row%0d_low", i), 32'(m_low), vecs[i].exp_low);
      chk($sformatf("row%0d_sat_valid", i), 32'(s_valid), 1);
      chk_tol($sformatf("row%0d_sat_result", i), 32'(s_result), vecs[i].exp2_res, vecs[i].tol);
      chk($sformatf("row%0d_sat_over", i), 32'(s_over), vecs[i].exp2_over);
      chk($sformatf("row%0d_sat_low", i), 32'(s_low), vecs[i].exp2_low);
      @(negedge clk);
      chk($sformatf("row%0d_pulse_width", i), 32'({m_valid, m_over, m_low}), 0);
      m = 1;
      while (!m_busy && m < 100) begin
        @(negedge clk);
        m++;
      end
      chk($sformatf("row%0d_hold_restart", i), m, 20);
    end

    // Abort at gate cycle 400: prior result stays, new gate completes gate_len+2 after the abort.
    sig_per   = 2;
    range_sel = 2'b01;
    repeat (20) @(negedge clk);
    start_pulse();
    quiet = 1;
    repeat (400) begin
      @(negedge clk);
      if (m_valid) quiet = 0;
    end
    start_pulse();
    chk("abort_quiet", quiet, 1);
    chk("abort_prior_result", 32'(m_result), 250);
    wait_valid(1100, n);
    chk("abort_latency", n, 1002);
    chk("abort_new_result", 32'(m_result), 500);

    // Range 11 gates for 1000 cycles; start request during LATCH suppresses all pulses.
    range_sel = 2'b11;
    sig_per   = 4;
    repeat (20) @(negedge clk);
    start_pulse();
    quiet = 1;
    for (int k = 0; k < 1001; k++) begin
      @(negedge clk);
      if (m_valid) quiet = 0;
    end
    chk("r11_no_early_valid", quiet, 1);
    chk("r11_busy_in_latch", 32'(m_busy), 1);
    start_pulse();
    chk("latch_abort_pulses", 32'({m_valid, m_over, m_low}), 0);
    chk("latch_abort_clear_busy", 32'(m_busy), 1);
    chk("latch_abort_result_held", 32'(m_result), 500);
    wait_valid(1100, n);
    chk("r11_latency", n, 1002);
    chk("r11_result", 32'(m_result), 250);
    chk("r11_range", 32'(m_range), 3);
    chk("r11_low", 32'(m_low), 1);

    // Reset in the middle of a gate clears everything at once and stays idle afterwards.
    range_sel = 2'b01;
    sig_per   = 2;
    start_pulse();
    repeat (50) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_result", 32'(m_result), 0);
    chk("midreset_range", 32'(m_range), 0);
    chk("midreset_busy", 32'(m_busy), 0);
    chk("midreset_pulses", 32'({m_valid, m_over, m_low}), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    quiet = 1;
    repeat (300) begin
      @(negedge clk);
      if (m_valid || m_busy || m_over || m_low) quiet = 0;
    end
    chk("post_reset_idle", quiet, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
